// File: rtl/nd_2to1_arb.sv
// Merges two toggle-handshake receive channels onto one send channel; NS_ARB_ROUND_ROBIN_EN selects round-robin ties, else input 0 wins.
// Latency: 2 synchronizer edges plus 1 grant edge from rcvN_req toggle to snd0_req/rcvN_ack toggle; the snd0 register is the only buffer.
// Backpressure: no grant while snd0_req is unacknowledged downstream; pending inputs simply keep their request.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_arb #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,

    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,

    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,

    output logic           last_gnt
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0] state;
    logic       rst_cnt;
    logic [1:0] req0_sync;
    logic [1:0] req1_sync;
    logic [1:0] ack_sync;
    logic       pend0;
    logic       pend1;
    logic       gnt_vld;
    logic       gnt_sel;

    // Producers and consumer may run on unrelated clocks; only toggles cross.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            req0_sync <= 2'b00;
            req1_sync <= 2'b00;
            ack_sync  <= 2'b00;
        end else begin
            req0_sync <= {req0_sync[0], rcv0_req};
            req1_sync <= {req1_sync[0], rcv1_req};
            ack_sync  <= {ack_sync[0], snd0_ack};
        end
    end

    assign pend0 = req0_sync[1] ^ rcv0_ack;
    assign pend1 = req1_sync[1] ^ rcv1_ack;

    always_comb begin
        gnt_vld = (state == ST_IDLE) && (pend0 || pend1);
        gnt_sel = pend1;
        if (pend0 && pend1) begin
`ifdef NS_ARB_ROUND_ROBIN_EN
            gnt_sel = ~last_gnt;
`else
            gnt_sel = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RST;
            rst_cnt  <= 1'b0;
            ready    <= 1'b0;
            last_gnt <= 1'b1;
            rcv0_ack <= 1'b0;
            rcv1_ack <= 1'b0;
            snd0_req <= 1'b0;
            snd0_src <= '0;
            snd0_dst <= '0;
            snd0_dat <= '0;
            snd0_red <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    // Two edges after release lets the synchronizers flush.
                    if (rst_cnt) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        rst_cnt <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (gnt_vld) begin
                        if (gnt_sel) begin
                            snd0_src <= rcv1_src;
                            snd0_dst <= rcv1_dst;
                            snd0_dat <= rcv1_dat;
                            snd0_red <= rcv1_red;
                            rcv1_ack <= ~rcv1_ack;
                        end else begin
                            snd0_src <= rcv0_src;
                            snd0_dst <= rcv0_dst;
                            snd0_dat <= rcv0_dat;
                            snd0_red <= rcv0_red;
                            rcv0_ack <= ~rcv0_ack;
                        end
                        snd0_req <= ~snd0_req;
                        last_gnt <= gnt_sel;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ack_sync[1] == snd0_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_nd_2to1_arb.sv
// Randomized bench for nd_2to1_arb: toggle-handshake producers/consumer with a per-channel FIFO scoreboard.
module tb_nd_2to1_arb;

    logic       i_clk;
    logic       reset;
    logic       ready;
    logic       rcv0_req, rcv0_ack, rcv1_req, rcv1_ack;
    logic [5:0] rcv0_src, rcv0_dst, rcv1_src, rcv1_dst;
    logic [3:0] rcv0_dat, rcv0_red, rcv1_dat, rcv1_red;
    logic       snd0_req;
    logic       cack;
    logic [5:0] snd0_src, snd0_dst;
    logic [3:0] snd0_dat, snd0_red;
    logic       last_gnt;

    nd_2to1_arb #(.ASZ(6), .DSZ(4), .RSZ(4)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack), .rcv0_src(rcv0_src),
        .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
        .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack), .rcv1_src(rcv1_src),
        .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_red(rcv1_red),
        .snd0_req(snd0_req), .snd0_ack(cack), .snd0_src(snd0_src),
        .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
        .last_gnt(last_gnt)
    );

    // Message packing: {src[19:14], dst[13:8], dat[7:4], red[3:0]}
    logic [19:0] tx0[$], tx1[$], exp0[$], exp1[$];
    logic [3:0]  ord[$];
    logic [3:0]  exp_ord [8];
    logic [19:0] last_rx;
    int          cyc, tx_cyc0, rx_cyc;
    int          ack_dly, gap_max, gap0, gap1;
    bit          rand_ack;
    int          n_checks, n_errors;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Producer 0: presents a new message once its previous one was acknowledged.
    initial begin
        logic [19:0] m;
        rcv0_req = 1'b0;
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = '0;
        gap0 = 0;
        forever begin
            @(posedge i_clk); #1;
            if (reset) begin
                rcv0_req = 1'b0;
                tx0.delete();
            end else if (ready && tx0.size() != 0 && rcv0_req == rcv0_ack) begin
                if (gap0 != 0) gap0--;
                else begin
                    m = tx0.pop_front();
                    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
                    rcv0_req = ~rcv0_req;
                    exp0.push_back(m);
                    tx_cyc0 = cyc;
                    gap0 = $urandom_range(0, gap_max);
                end
            end
        end
    end

    initial begin
        logic [19:0] m;
        rcv1_req = 1'b0;
        {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = '0;
        gap1 = 0;
        forever begin
            @(posedge i_clk); #1;
            if (reset) begin
                rcv1_req = 1'b0;
                tx1.delete();
            end else if (ready && tx1.size() != 0 && rcv1_req == rcv1_ack) begin
                if (gap1 != 0) gap1--;
                else begin
                    m = tx1.pop_front();
                    {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = m;
                    rcv1_req = ~rcv1_req;
                    exp1.push_back(m);
                    gap1 = $urandom_range(0, gap_max);
                end
            end
        end
    end

    // Consumer: each delivered message must be the oldest outstanding one of some channel.
    initial begin
        logic [19:0] got;
        bit m0, m1, ch;
        int dly;
        cack = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (reset) cack = 1'b0;
            else if (snd0_req != cack) begin
                got = {snd0_src, snd0_dst, snd0_dat, snd0_red};
                last_rx = got;
                rx_cyc = cyc;
                ord.push_back(snd0_dat);
                m0 = exp0.size() != 0 && exp0[0] == got;
                m1 = exp1.size() != 0 && exp1[0] == got;
                ch = (m0 && m1) ? last_gnt : m1;
                chk("sb_match", 32'(m0 || m1), 32'd1);
                if (m0 || m1) begin
                    chk("gnt_index", 32'(last_gnt), 32'(ch));
                    if (ch) void'(exp1.pop_front());
                    else    void'(exp0.pop_front());
                end
                dly = rand_ack ? int'($urandom_range(0, 6)) : ack_dly;
                for (int i = 0; i < dly && !reset; i++) begin
                    @(posedge i_clk); #1;
                end
                if (!reset) cack = ~cack;
            end
        end
    end

    // Protocol monitor, sampled between clock edges.
    initial begin
        logic p_req, p_cack, p_a0, p_a1;
        logic [19:0] p_pl;
        p_req = 0; p_cack = 0; p_a0 = 0; p_a1 = 0; p_pl = '0;
        forever begin
            @(negedge i_clk);
            if (!reset) begin
                if (rcv0_ack != p_a0 || rcv1_ack != p_a1) begin
                    chk("ack_with_grant", 32'(snd0_req != p_req), 32'd1);
                    chk("single_ack", 32'((rcv0_ack ^ p_a0) ^ (rcv1_ack ^ p_a1)), 32'd1);
                end
                if (snd0_req != p_req)
                    chk("one_outstanding", 32'(p_req == p_cack), 32'd1);
                else
                    chk("payload_hold", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'(p_pl));
            end
            p_req = snd0_req; p_cack = cack; p_a0 = rcv0_ack; p_a1 = rcv1_ack;
            p_pl = {snd0_src, snd0_dst, snd0_dat, snd0_red};
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_last_gnt", 32'(last_gnt), 32'd1);
        chk("rst_rcv0_ack", 32'(rcv0_ack), 32'd0);
        chk("rst_rcv1_ack", 32'(rcv1_ack), 32'd0);
        chk("rst_snd0_req", 32'(snd0_req), 32'd0);
        chk("rst_payload", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'd0);
        exp0.delete();
        exp1.delete();
        ord.delete();
        repeat (3) @(negedge i_clk);
        reset = 1'b0;
        @(posedge i_clk); #1;
        chk("ready_edge1", 32'(ready), 32'd0);
        @(posedge i_clk); #1;
        chk("ready_edge2", 32'(ready), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            @(posedge i_clk); #1;
            n++;
            busy = (tx0.size() + tx1.size() + exp0.size() + exp1.size() != 0) || (snd0_req != cack);
        end
        chk("drain", 32'(busy), 32'd0);
        repeat (4) @(posedge i_clk);
    endtask

    function automatic logic [19:0] rnd_msg(input logic [3:0] dat);
        logic [5:0] s, d;
        logic [3:0] r;
        s = 6'($urandom);
        d = 6'($urandom);
        r = 4'($urandom);
        return {s, d, dat, r};
    endfunction

    initial begin
        logic [19:0] m;
        int n, n0, n1;
        n_checks = 0; n_errors = 0;
        ack_dly = 3; gap_max = 0; rand_ack = 0;
`ifdef NS_ARB_ROUND_ROBIN_EN
        exp_ord = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12};
`else
        exp_ord = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        do_reset();

        // Single message on rcv0.
        @(negedge i_clk);
        m = rnd_msg(4'd5);
        m[13:8] = 6'd30;
        tx0.push_back(m);
        wait_drain(200);
        chk("single_latency", 32'(rx_cyc - tx_cyc0), 32'd3);
        chk("single_dst", 32'(last_rx[13:8]), 32'd30);
        chk("single_dat", 32'(last_rx[7:4]), 32'd5);
        chk("single_payload", 32'(last_rx), 32'(m));
        chk("single_ack", 32'(rcv0_ack), 32'(rcv0_req));
        chk("single_gnt", 32'(last_gnt), 32'd0);

        // Both inputs streaming from a fresh reset.
        do_reset();
        @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            tx0.push_back(rnd_msg(4'(i + 1)));
            tx1.push_back(rnd_msg(4'(i + 9)));
        end
        wait_drain(400);
        chk("tie_count", 32'(ord.size()), 32'd8);
        for (int i = 0; i < 8 && i < ord.size(); i++)
            chk("tie_order", 32'(ord[i]), 32'(exp_ord[i]));

        // Slow consumer.
        ack_dly = 20;
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            tx0.push_back(rnd_msg(4'($urandom)));
            tx1.push_back(rnd_msg(4'($urandom)));
        end
        wait_drain(1000);

        // Random traffic, gaps and ack delays.
        rand_ack = 1; gap_max = 3;
        for (int r = 0; r < 4; r++) begin
            @(negedge i_clk);
            n0 = $urandom_range(2, 8);
            n1 = $urandom_range(2, 8);
            for (int i = 0; i < n0; i++) tx0.push_back(rnd_msg(4'($urandom)));
            for (int i = 0; i < n1; i++) tx1.push_back(rnd_msg(4'($urandom)));
            wait_drain(2000);
        end
        rand_ack = 0; gap_max = 0;
        repeat (5) @(posedge i_clk);

        // Reset while a message is in SEND, then a fresh message on rcv1.
        ack_dly = 20;
        @(negedge i_clk);
        tx0.push_back(rnd_msg(4'd7));
        n = 0;
        while (snd0_req == cack && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("send_reached", 32'(snd0_req != cack), 32'd1);
        repeat (3) @(posedge i_clk);
        do_reset();
        ack_dly = 3;
        @(negedge i_clk);
        m = rnd_msg(4'd6);
        tx1.push_back(m);
        wait_drain(200);
        chk("fresh_payload", 32'(last_rx), 32'(m));
        chk("fresh_gnt", 32'(last_gnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
